// File: rtl/wifi_tx_mapper_sched.sv
// Read-side sequencer for the WIFI TX mapper bit FIFO.
// It tracks how full the FIFO is and reads one bit per cycle, in groups of N_BPSC bits.
// Each group is packed into one symbol word and passed to the constellation mapper
// with a valid/ready handshake. The final symbol of a frame is zero-padded in its LSBs.
module wifi_tx_mapper_sched #(
    parameter int unsigned AD   = 14,
    parameter int unsigned MAXB = 6
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      mod_sel_i,
    input  logic [AD:0]     len_bits_i,
    input  logic            wr_strobe_i,
    output logic            fifo_re_o,
    input  logic            fifo_valid_i,
    input  logic            fifo_data_i,
    output logic [MAXB-1:0] sym_bits_o,
    output logic [1:0]      sym_mod_o,
    output logic            sym_valid_o,
    input  logic            sym_ready_i,
    output logic            sym_last_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int unsigned CW = AD + 1;
    localparam int unsigned NW = 3;
    localparam logic [CW-1:0] OCC_MAX = CW'(1) << AD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_COLLECT,
        S_OUT,
        S_FIN
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic [NW-1:0]   issued_q, issued_d;
    logic [NW-1:0]   got_q, got_d;
    logic [MAXB-1:0] shreg_q, shreg_d;
    logic [1:0]      mod_q, mod_d;
    logic [MAXB-1:0] sym_bits_q, sym_bits_d;
    logic            sym_valid_q, sym_valid_d;
    logic            sym_last_q, sym_last_d;
    logic            fifo_re_q, fifo_re_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NW-1:0]   n_c;
    logic [NW-1:0]   need_c;

    // Bits per symbol for each modulation
    function automatic logic [NW-1:0] bits_per_sym(input logic [1:0] m);
        case (m)
            2'd0:    return NW'(1);
            2'd1:    return NW'(2);
            2'd2:    return NW'(4);
            default: return NW'(6);
        endcase
    endfunction

    // Group size: full N, or whatever is left of the frame for the last group
    always_comb begin
        n_c    = bits_per_sym(mod_q);
        need_c = (remain_q < CW'(n_c)) ? NW'(remain_q) : n_c;
    end

    // FIFO occupancy: +1 per write, -1 per read, saturating at both ends
    always_comb begin
        occ_d = occ_q;
        if (wr_strobe_i && !fifo_re_q) begin
            if (occ_q != OCC_MAX) occ_d = occ_q + CW'(1);
        end else if (!wr_strobe_i && fifo_re_q) begin
            if (occ_q != '0) occ_d = occ_q - CW'(1);
        end
    end

    // Next state and registered outputs
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        issued_d    = issued_q;
        got_d       = got_q;
        shreg_d     = shreg_q;
        mod_d       = mod_q;
        sym_bits_d  = sym_bits_q;
        sym_valid_d = sym_valid_q;
        sym_last_d  = sym_last_q;
        fifo_re_d   = 1'b0;
        done_d      = 1'b0;

        // Read data is taken while reads are issued or pending; extra pulses are dropped
        if ((state_q == S_READ || state_q == S_COLLECT) && fifo_valid_i && (got_q < need_c)) begin
            shreg_d = {shreg_q[MAXB-2:0], fifo_data_i};
            got_d   = got_q + NW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mod_d    = mod_sel_i;
                    remain_d = len_bits_i;
                    state_d  = (len_bits_i == '0) ? S_FIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (occ_q >= CW'(need_c)) begin
                    got_d     = '0;
                    shreg_d   = '0;
                    fifo_re_d = (occ_d != '0);
                    issued_d  = NW'(fifo_re_d);
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                if (issued_q == need_c) begin
                    state_d = S_COLLECT;
                end else begin
                    // Hold off for a cycle whenever the FIFO would be empty
                    fifo_re_d = (occ_d != '0);
                    issued_d  = issued_q + NW'(fifo_re_d);
                end
            end
            S_COLLECT: begin
                if (got_d == need_c) begin
                    sym_bits_d  = shreg_d << (n_c - need_c);
                    sym_valid_d = 1'b1;
                    sym_last_d  = (remain_q == CW'(need_c));
                    remain_d    = remain_q - CW'(need_c);
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (sym_ready_i) begin
                    sym_valid_d = 1'b0;
                    sym_last_d  = 1'b0;
                    state_d     = sym_last_q ? S_FIN : S_WAIT;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            occ_q       <= '0;
            remain_q    <= '0;
            issued_q    <= '0;
            got_q       <= '0;
            shreg_q     <= '0;
            mod_q       <= '0;
            sym_bits_q  <= '0;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            fifo_re_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            remain_q    <= remain_d;
            issued_q    <= issued_d;
            got_q       <= got_d;
            shreg_q     <= shreg_d;
            mod_q       <= mod_d;
            sym_bits_q  <= sym_bits_d;
            sym_valid_q <= sym_valid_d;
            sym_last_q  <= sym_last_d;
            fifo_re_q   <= fifo_re_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fifo_re_o   = fifo_re_q;
    assign sym_bits_o  = sym_bits_q;
    assign sym_mod_o   = mod_q;
    assign sym_valid_o = sym_valid_q;
    assign sym_last_o  = sym_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_wifi_tx_mapper_sched.sv
// Bench for wifi_tx_mapper_sched.
// Contains a bit-FIFO model with one cycle of read latency and a scoreboard of expected symbols.
module tb_wifi_tx_mapper_sched;

    localparam int unsigned AD   = 14;
    localparam int unsigned MAXB = 6;
    localparam int unsigned CW   = AD + 1;

    typedef struct packed {
        logic [5:0] bits;
        logic       last;
        logic [1:0] mod;
    } sym_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      mod_sel;
    logic [CW-1:0]   len_bits;
    logic            wr_strobe;
    logic            wr_bit;
    logic            fifo_re_o;
    logic            fifo_valid = 1'b0;
    logic            fifo_data = 1'b0;
    logic [MAXB-1:0] sym_bits_o;
    logic [1:0]      sym_mod_o;
    logic            sym_valid_o;
    logic            sym_ready;
    logic            sym_last_o;
    logic            busy_o;
    logic            done_o;

    int   total = 0;
    int   bad = 0;
    int   re_cnt = 0;
    int   done_cnt = 0;
    sym_t exp_q[$];
    bit   fifo_q[$];

    logic re_s = 1'b0, wr_s = 1'b0, wb_s = 1'b0, rst_s = 1'b0;
    logic hold_act = 1'b0;
    logic [MAXB-1:0] hold_bits = '0;
    logic hold_last = 1'b0;

    always #5 clk = ~clk;

    wifi_tx_mapper_sched #(.AD(AD), .MAXB(MAXB)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .mod_sel_i    (mod_sel),
        .len_bits_i   (len_bits),
        .wr_strobe_i  (wr_strobe),
        .fifo_re_o    (fifo_re_o),
        .fifo_valid_i (fifo_valid),
        .fifo_data_i  (fifo_data),
        .sym_bits_o   (sym_bits_o),
        .sym_mod_o    (sym_mod_o),
        .sym_valid_o  (sym_valid_o),
        .sym_ready_i  (sym_ready),
        .sym_last_o   (sym_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample mid-cycle: FIFO requests, done pulses and symbol handshakes
    always @(negedge clk) begin
        sym_t e;
        re_s  = fifo_re_o;
        wr_s  = wr_strobe;
        wb_s  = wr_bit;
        rst_s = !reset;
        if (fifo_re_o) begin
            re_cnt++;
            check("fifo_read_while_empty", 32'(fifo_q.size() != 0), 32'd1);
        end
        if (done_o) done_cnt++;
        if (sym_valid_o) begin
            if (hold_act) begin
                check("hold_bits", 32'(sym_bits_o), 32'(hold_bits));
                check("hold_last", 32'(sym_last_o), 32'(hold_last));
            end
            if (sym_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sym_unexpected: got bits=0x%0h with nothing expected", sym_bits_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sym_bits", 32'(sym_bits_o), 32'(e.bits));
                    check("sym_last", 32'(sym_last_o), 32'(e.last));
                    check("sym_mod", 32'(sym_mod_o), 32'(e.mod));
                end
                hold_act = 1'b0;
            end else begin
                hold_act  = 1'b1;
                hold_bits = sym_bits_o;
                hold_last = sym_last_o;
            end
        end else begin
            hold_act = 1'b0;
        end
    end

    // FIFO model: a read in a cycle returns its bit in the following cycle
    always @(posedge clk) begin
        #1;
        if (re_s && fifo_q.size() != 0) begin
            fifo_data  = fifo_q.pop_front();
            fifo_valid = 1'b1;
        end else begin
            fifo_data  = 1'b0;
            fifo_valid = 1'b0;
        end
        if (wr_s) fifo_q.push_back(wb_s);
        if (rst_s) fifo_q.delete();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bits(input logic [15:0] b, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            wr_strobe = 1'b1;
            wr_bit    = b[n-1-i];
            tick();
            wr_strobe = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic start_frame(input logic [1:0] m, input int len);
        start    = 1'b1;
        mod_sel  = m;
        len_bits = CW'(len);
        tick();
        start    = 1'b0;
    endtask

    task automatic expect_sym(input logic [5:0] b, input logic l, input logic [1:0] m);
        sym_t s;
        s.bits = b;
        s.last = l;
        s.mod  = m;
        exp_q.push_back(s);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic end_frame(input string name, input int re0, input int d0, input int re_exp);
        repeat (3) tick();
        check({name, "_re_count"}, 32'(re_cnt - re0), 32'(re_exp));
        check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_low"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int re0;
        int d0;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int re0;
        int d0;
        bit seen;
        reset = 1'b0; start = 1'b0; mod_sel = '0; len_bits = '0;
        wr_strobe = 1'b0; wr_bit = 1'b0; sym_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", 32'({fifo_re_o, sym_bits_o, sym_mod_o, sym_valid_o,
                                    sym_last_o, busy_o, done_o}), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 1: QPSK, 8 bits preloaded
        re0 = re_cnt; d0 = done_cnt;
        write_bits(16'b10110010, 8, 0);
        tick();
        expect_sym(6'd2, 1'b0, 2'd1);
        expect_sym(6'd3, 1'b0, 2'd1);
        expect_sym(6'd0, 1'b0, 2'd1);
        expect_sym(6'd2, 1'b1, 2'd1);
        start_frame(2'd1, 8);
        @(negedge clk);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_re_cycle1", 32'(fifo_re_o), 32'd0);
        @(negedge clk);
        check("t1_re_cycle2", 32'(fifo_re_o), 32'd1);
        wait_done("t1", 300);
        end_frame("t1", re0, d0, 8);

        // 2: 64QAM, 8 ones -> full symbol then 2 bits padded
        re0 = re_cnt; d0 = done_cnt;
        write_bits(16'hFFFF, 8, 0);
        tick();
        expect_sym(6'b111111, 1'b0, 2'd3);
        expect_sym(6'b110000, 1'b1, 2'd3);
        start_frame(2'd3, 8);
        wait_done("t2", 300);
        end_frame("t2", re0, d0, 8);

        // 3: BPSK with writes trickled in every 5 cycles
        re0 = re_cnt; d0 = done_cnt;
        expect_sym(6'd1, 1'b0, 2'd0);
        expect_sym(6'd0, 1'b0, 2'd0);
        expect_sym(6'd0, 1'b0, 2'd0);
        expect_sym(6'd1, 1'b1, 2'd0);
        start_frame(2'd0, 4);
        repeat (3) begin
            @(negedge clk);
            check("t3_no_re_when_empty", 32'(fifo_re_o), 32'd0);
        end
        tick();
        write_bits(16'b1001, 4, 4);
        wait_done("t3", 300);
        end_frame("t3", re0, d0, 4);

        // 4: 16QAM with the first symbol back-pressured for 10 cycles
        re0 = re_cnt; d0 = done_cnt;
        write_bits(16'b10010110, 8, 0);
        tick();
        expect_sym(6'd9, 1'b0, 2'd2);
        expect_sym(6'd6, 1'b1, 2'd2);
        sym_ready = 1'b0;
        start_frame(2'd2, 8);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (sym_valid_o) seen = 1'b1;
        end
        check("t4_valid_seen", 32'(seen), 32'd1);
        check("t4_re_before_stall", 32'(re_cnt - re0), 32'd4);
        repeat (10) begin
            @(negedge clk);
            check("t4_valid_held", 32'(sym_valid_o), 32'd1);
        end
        check("t4_no_extra_re", 32'(re_cnt - re0), 32'd4);
        tick();
        sym_ready = 1'b1;
        wait_done("t4", 300);
        end_frame("t4", re0, d0, 8);

        // 5: reset in the middle of a 64QAM read burst, then a clean QPSK frame
        write_bits(16'hFFF, 12, 0);
        tick();
        start_frame(2'd3, 12);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (fifo_re_o) seen = 1'b1;
        end
        check("t5_read_seen", 32'(seen), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_outputs_after_reset", 32'({fifo_re_o, sym_bits_o, sym_mod_o, sym_valid_o,
                                             sym_last_o, busy_o, done_o}), 32'd0);
        repeat (3) tick();
        re0 = re_cnt; d0 = done_cnt;
        write_bits(16'b0111, 4, 0);
        tick();
        expect_sym(6'd1, 1'b0, 2'd1);
        expect_sym(6'd3, 1'b1, 2'd1);
        start_frame(2'd1, 4);
        wait_done("t5", 300);
        end_frame("t5", re0, d0, 4);

        // 6: zero-length frame, then start pulses ignored while busy
        re0 = re_cnt; d0 = done_cnt;
        start_frame(2'd2, 0);
        @(negedge clk);
        check("t6_done_cycle1", 32'(done_o), 32'd0);
        @(negedge clk);
        check("t6_done_cycle2", 32'(done_o), 32'd1);
        @(negedge clk);
        check("t6_done_cycle3", 32'(done_o), 32'd0);
        tick();
        check("t6_zero_len_re", 32'(re_cnt - re0), 32'd0);
        check("t6_zero_len_done", 32'(done_cnt - d0), 32'd1);

        re0 = re_cnt; d0 = done_cnt;
        expect_sym(6'd1, 1'b0, 2'd0);
        expect_sym(6'd0, 1'b1, 2'd0);
        start_frame(2'd0, 2);
        tick();
        start_frame(2'd3, 6);
        tick();
        write_bits(16'b10, 2, 0);
        wait_done("t6", 300);
        end_frame("t6", re0, d0, 2);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
